// File: rtl/uart_rx_buffered.sv
// ============================================================================
// Module  : uart_rx_buffered
// Brief   : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a
//           first-word-fall-through byte FIFO drained by a pop strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffered #(
  parameter int SAMPLE_MULTIPLIER = 8,
  parameter int FIFO_AW           = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken,
  input  logic               rx,
  input  logic               rd,
  input  logic               clr_err,
  output logic [7:0]         rdata,
  output logic               rvalid,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun
);

  localparam int                 c_cw    = $clog2(SAMPLE_MULTIPLIER);
  localparam logic [c_cw-1:0]    c_mid   = c_cw'(SAMPLE_MULTIPLIER / 2 - 1);
  localparam logic [c_cw-1:0]    c_last  = c_cw'(SAMPLE_MULTIPLIER - 1);
  localparam logic [FIFO_AW:0]   c_depth = (FIFO_AW + 1)'(1 << FIFO_AW);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rx_meta, r_rx_s;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              w_push, w_frame_err;
  logic              r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic              r_par_bad, w_par_bad_nxt;
  logic              w_parity_err, r_parity_err;
`endif

  logic [7:0]          r_mem [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW-1:0]  r_wptr, r_rptr;
  logic [FIFO_AW:0]    r_count;
  logic                r_overrun;
  logic                w_pop, w_full, w_wr, w_ovr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad_nxt;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_parity_err  = 1'b0;
`endif
    if (clken) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          // Mid start bit: a line back high here was only a glitch.
          if (r_cnt == c_mid) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == c_last) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == c_last) begin
            w_cnt_nxt     = '0;
            w_par_bad_nxt = ^{r_shift, r_rx_s};
            w_state_nxt   = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start is caught.
          if (r_cnt == c_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
            if (!r_rx_s) begin
              w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              w_parity_err = 1'b1;
`endif
            end else begin
              w_push = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A push into a full FIFO still lands when a pop frees the head slot.
  assign w_pop     = rd & rvalid;
  assign w_full    = (r_count == c_depth);
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
    end
  end

  assign rvalid    = (r_count != '0);
  assign rdata     = rvalid ? r_mem[r_rptr] : 8'h00;
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
// ============================================================================
// Module  : tb_uart_rx_buffered
// Brief   : Directed bench for uart_rx_buffered; clken every 34 clk, 272 clk/bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffered;

  localparam int c_bit = 272;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [4:0] count;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;

  uart_rx_buffered #(.SAMPLE_MULTIPLIER(8), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .clken(clken), .rx(rx), .rd(rd), .clr_err(clr_err),
    .rdata(rdata), .rvalid(rvalid), .count(count), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (33) @(negedge clk);
      clken = 1'b1;
      @(negedge clk);
      clken = 1'b0;
    end
  end

  // Pulse-width sensitive: a stuck pulse counts more than once.
  always @(negedge clk) begin
    if (frame_err === 1'b1)  fe_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (c_bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (c_bit) @(negedge clk);
    end
    rx = stop_bit;
    repeat (c_bit) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int fe0;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {frame_err, parity_err, overrun}, 0);

    // Single byte
    send_frame(8'h41, 1'b1);
    repeat (10) @(negedge clk);
    check("b41_rvalid", rvalid, 1);
    check("b41_rdata", rdata, 8'h41);
    check("b41_count", count, 1);
    check("b41_busy", busy, 0);
    check("b41_errs", fe_cnt + pe_cnt, 0);
    pop();
    check("b41_empty", rvalid, 0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check("b2b_count", count, 3);
    check("b2b_pop0", rdata, 8'h00);
    pop();
    check("b2b_pop1", rdata, 8'hFF);
    pop();
    check("b2b_pop2", rdata, 8'h55);
    pop();
    check("b2b_empty", count, 0);

    // Start-bit glitch rejected silently
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (68) @(negedge clk);
    rx = 1'b1;
    repeat (2 * c_bit) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_rvalid", rvalid, 0);
    check("glitch_fe", fe_cnt - fe0, 0);

    // Bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2 * c_bit) @(negedge clk);
    check("frame_err_pulse", fe_cnt - fe0, 1);
    check("frame_count", count, 0);
    check("frame_busy", busy, 0);

    // 17 bytes into a 16-deep FIFO
    fe0 = fe_cnt;
    for (int i = 0; i < 17; i++) send_frame(i[7:0], 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_count", count, 16);
    check("ovr_flag", overrun, 1);
    check("ovr_fe", fe_cnt - fe0, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_pop%0d", i), rdata, i);
      pop();
    end
    check("ovr_drained", {rvalid, count}, 0);
    check("ovr_sticky", overrun, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Reset mid-frame flushes FIFO and aborts the partial byte
    send_frame(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst_count", count, 1);
    b = 8'hA5;
    rx = 1'b0;
    repeat (c_bit) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (c_bit) @(negedge clk);
    end
    rx = b[4];
    repeat (c_bit / 2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_outputs", {rdata, rvalid, count, busy, frame_err, parity_err, overrun}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * c_bit) @(negedge clk);
    fe0 = fe_cnt;
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    check("post_rst_rdata", rdata, 8'h5A);
    check("post_rst_count", count, 1);
    check("post_rst_fe", fe_cnt - fe0, 0);
    check("parity_never", pe_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
